// File: rtl/stream_distributor_if.sv
// stream_distributor_if: shared input stream plus two output streams of the distributor.
interface stream_distributor_if #(parameter int WIDTH0 = 32, parameter int WIDTH1 = 32);
  logic                     iValid_AM;
  logic                     oReady_AM;
  logic                     iSelect_AM;
  logic [WIDTH1+WIDTH0-1:0] iData_AM;
  logic                     oValid_BM0;
  logic                     iReady_BM0;
  logic [WIDTH0-1:0]        oData_BM0;
  logic                     oValid_BM1;
  logic                     iReady_BM1;
  logic [WIDTH1-1:0]        oData_BM1;
  modport master (
    output iValid_AM, iSelect_AM, iData_AM, iReady_BM0, iReady_BM1,
    input  oReady_AM, oValid_BM0, oData_BM0, oValid_BM1, oData_BM1
  );
  modport slave (
    input  iValid_AM, iSelect_AM, iData_AM, iReady_BM0, iReady_BM1,
    output oReady_AM, oValid_BM0, oData_BM0, oValid_BM1, oData_BM1
  );
endinterface

// File: rtl/stream_distributor.sv
// stream_distributor: splits one {select, data1, data0} stream into two buffered output streams.
// Optional per-channel transfer counters are enabled with macro DISTRIBUTOR_COUNT_EN.
module stream_distributor_buf #(
  parameter int W     = 32,
  parameter     BURST = "yes"
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         i_wr,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_space,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  logic w_rd;
  assign w_rd = o_valid && i_ready;
  generate
    if (BURST == "yes") begin : g_burst
      state_t r_state;
      logic r_valid, r_space;
      logic [W-1:0] r_main, r_skid;
      always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
          r_space <= 1'b1;
        end else
          case (r_state)
            EMPTY: if (i_wr) begin
              r_state <= ONE;
              r_valid <= 1'b1;
            end
            ONE: if (i_wr && !w_rd) begin
              r_state <= TWO;
              r_space <= 1'b0;
            end else if (!i_wr && w_rd) begin
              r_state <= EMPTY;
              r_valid <= 1'b0;
            end
            default: if (w_rd) begin
              r_state <= ONE;
              r_space <= 1'b1;
            end
          endcase
      // skid only fills when main is busy and not draining this cycle
      always_ff @(posedge iCLK) begin
        if (i_wr && (r_state == EMPTY || w_rd)) r_main <= i_data;
        else if (w_rd) r_main <= r_skid;
        if (i_wr && r_state == ONE && !w_rd) r_skid <= i_data;
      end
      assign o_valid = r_valid;
      assign o_space = r_space;
      assign o_data  = r_main;
    end else begin : g_single
      logic r_valid;
      logic [W-1:0] r_data;
      always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) r_valid <= 1'b0;
        else if (i_wr) r_valid <= 1'b1;
        else if (w_rd) r_valid <= 1'b0;
      always_ff @(posedge iCLK)
        if (i_wr) r_data <= i_data;
      assign o_valid = r_valid;
      assign o_space = !r_valid;
      assign o_data  = r_data;
    end
  endgenerate
endmodule

module stream_distributor #(
  parameter int WIDTH0      = 32,
  parameter int WIDTH1      = 32,
  parameter     BURST       = "yes",
  parameter int COUNT_WIDTH = 16
) (
  input logic iCLK,
  input logic iRST,
  stream_distributor_if.slave s
`ifdef DISTRIBUTOR_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] oCount0,
  output logic [COUNT_WIDTH-1:0] oCount1
`endif
);
  logic w_space0, w_space1, w_wr0, w_wr1;
  // head-of-line blocking: readiness follows only the selected channel
  assign s.oReady_AM = s.iSelect_AM ? w_space1 : w_space0;
  assign w_wr0 = s.iValid_AM && !s.iSelect_AM && w_space0;
  assign w_wr1 = s.iValid_AM && s.iSelect_AM && w_space1;
  stream_distributor_buf #(.W(WIDTH0), .BURST(BURST)) u_buf0 (
    .iCLK(iCLK), .iRST(iRST), .i_wr(w_wr0), .i_data(s.iData_AM[WIDTH0-1:0]),
    .i_ready(s.iReady_BM0), .o_space(w_space0), .o_valid(s.oValid_BM0), .o_data(s.oData_BM0)
  );
  stream_distributor_buf #(.W(WIDTH1), .BURST(BURST)) u_buf1 (
    .iCLK(iCLK), .iRST(iRST), .i_wr(w_wr1), .i_data(s.iData_AM[WIDTH1+WIDTH0-1:WIDTH0]),
    .i_ready(s.iReady_BM1), .o_space(w_space1), .o_valid(s.oValid_BM1), .o_data(s.oData_BM1)
  );
`ifdef DISTRIBUTOR_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_count0, r_count1;
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      r_count0 <= '0;
      r_count1 <= '0;
    end else begin
      r_count0 <= r_count0 + COUNT_WIDTH'(s.oValid_BM0 && s.iReady_BM0);
      r_count1 <= r_count1 + COUNT_WIDTH'(s.oValid_BM1 && s.iReady_BM1);
    end
  assign oCount0 = r_count0;
  assign oCount1 = r_count1;
`else
  logic w_unused_cw;
  assign w_unused_cw = ^COUNT_WIDTH;
`endif
endmodule

// File: tb/tb_stream_distributor.sv
// tb_stream_distributor: vector table plus queue-model random checks of BURST yes/no distributors.
module tb_stream_distributor;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_distributor_if #(.WIDTH0(32), .WIDTH1(32)) ifa ();
  stream_distributor_if #(.WIDTH0(32), .WIDTH1(32)) ifb ();
`ifdef DISTRIBUTOR_COUNT_EN
  logic [15:0] ca0, ca1, cb0, cb1;
`endif

  stream_distributor #(.WIDTH0(32), .WIDTH1(32), .BURST("yes")) u_a (
    .iCLK(clk), .iRST(rst_n), .s(ifa)
`ifdef DISTRIBUTOR_COUNT_EN
    , .oCount0(ca0), .oCount1(ca1)
`endif
  );
  stream_distributor #(.WIDTH0(32), .WIDTH1(32), .BURST("no")) u_b (
    .iCLK(clk), .iRST(rst_n), .s(ifb)
`ifdef DISTRIBUTOR_COUNT_EN
    , .oCount0(cb0), .oCount1(cb1)
`endif
  );

  int checks = 0, passed = 0;
  typedef logic [31:0] q_t[$];
  q_t mq[4];
  int mcnt[4];

  typedef struct {
    bit v, sel; logic [31:0] d1, d0; bit r0, r1;
    bit erdy, ev0; logic [31:0] ed0; bit ev1; logic [31:0] ed1;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit w, input bit v, input bit sel, input logic [31:0] d1, input logic [31:0] d0,
                       input bit r0, input bit r1);
    if (w) begin
      ifb.iValid_AM = v; ifb.iSelect_AM = sel; ifb.iData_AM = {d1, d0};
      ifb.iReady_BM0 = r0; ifb.iReady_BM1 = r1;
    end else begin
      ifa.iValid_AM = v; ifa.iSelect_AM = sel; ifa.iData_AM = {d1, d0};
      ifa.iReady_BM0 = r0; ifa.iReady_BM1 = r1;
    end
  endtask

  task automatic peek(input bit w, output logic rdy, output logic o0, output logic [31:0] x0,
                      output logic o1, output logic [31:0] x1);
    rdy = w ? ifb.oReady_AM : ifa.oReady_AM;
    o0  = w ? ifb.oValid_BM0 : ifa.oValid_BM0;
    x0  = w ? ifb.oData_BM0 : ifa.oData_BM0;
    o1  = w ? ifb.oValid_BM1 : ifa.oValid_BM1;
    x1  = w ? ifb.oData_BM1 : ifa.oData_BM1;
  endtask

  // One cycle against the queue model: a channel holds up to 2 items (BURST yes) or 1 (BURST no).
  task automatic mstep(input bit w, input bit v, input bit sel, input logic [31:0] d1, input logic [31:0] d0,
                       input bit r0, input bit r1, output bit acc);
    logic rdy, o0, o1;
    logic [31:0] x0, x1;
    int base, cap;
    bit er;
    string n;
    base = w ? 2 : 0;
    cap  = w ? 1 : 2;
    n    = w ? "b" : "a";
    drive(w, v, sel, d1, d0, r0, r1);
    #1;
    peek(w, rdy, o0, x0, o1, x1);
    er = sel ? (mq[base+1].size() < cap) : (mq[base].size() < cap);
    chk({n, ".ready"}, rdy, er);
    chk({n, ".valid0"}, o0, mq[base].size() > 0);
    if (mq[base].size() > 0) chk({n, ".data0"}, x0, mq[base][0]);
    chk({n, ".valid1"}, o1, mq[base+1].size() > 0);
    if (mq[base+1].size() > 0) chk({n, ".data1"}, x1, mq[base+1][0]);
`ifdef DISTRIBUTOR_COUNT_EN
    chk({n, ".count0"}, w ? cb0 : ca0, 16'(mcnt[base]));
    chk({n, ".count1"}, w ? cb1 : ca1, 16'(mcnt[base+1]));
`endif
    if (mq[base].size() > 0 && r0) begin void'(mq[base].pop_front()); mcnt[base]++; end
    if (mq[base+1].size() > 0 && r1) begin void'(mq[base+1].pop_front()); mcnt[base+1]++; end
    acc = v && er;
    if (acc) mq[base+sel].push_back(sel ? d1 : d0);
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(input bit w, input int n);
    bit acc = 1'b1, hv = 1'b0, hs = 1'b0;
    logic [31:0] h1 = '0, h0 = '0;
    for (int i = 0; i < n; i++) begin
      if (!(hv && !acc)) begin
        hv = $urandom_range(0, 3) != 0;
        hs = 1'($urandom_range(0, 1));
        h1 = $urandom;
        h0 = $urandom;
      end
      mstep(w, hv, hs, h1, h0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 4; i++) mstep(w, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    tv[0] = '{1'b1, 1'b0, 32'hB,  32'hA, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b0, 32'h0,  32'h2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b0, 32'h77, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 32'h0};
    tv[3] = '{1'b1, 1'b0, 32'h77, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 32'h0};
    tv[4] = '{1'b1, 1'b0, 32'h77, 32'h3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 32'h0};
    tv[5] = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[6] = '{1'b1, 1'b1, 32'hC,  32'h5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC};
    tv[7] = '{1'b1, 1'b1, 32'hD,  32'h6, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hD};
    tv[8] = '{1'b0, 1'b1, 32'h0,  32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    chk("rst.a.valid0", ifa.oValid_BM0, 1'b0);
    chk("rst.a.valid1", ifa.oValid_BM1, 1'b0);
    chk("rst.b.valid0", ifb.oValid_BM0, 1'b0);
    chk("rst.b.valid1", ifb.oValid_BM1, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.a.ready_sel0", ifa.oReady_AM, 1'b1);
    ifa.iSelect_AM = 1'b1;
    #1;
    chk("rst.a.ready_sel1", ifa.oReady_AM, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, tv[i].v, tv[i].sel, tv[i].d1, tv[i].d0, tv[i].r0, tv[i].r1);
      #1;
      chk($sformatf("tv%0d.ready", i), ifa.oReady_AM, tv[i].erdy);
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d.valid0", i), ifa.oValid_BM0, tv[i].ev0);
      if (tv[i].ev0) chk($sformatf("tv%0d.data0", i), ifa.oData_BM0, tv[i].ed0);
      chk($sformatf("tv%0d.valid1", i), ifa.oValid_BM1, tv[i].ev1);
      if (tv[i].ev1) chk($sformatf("tv%0d.data1", i), ifa.oData_BM1, tv[i].ed1);
    end
    mcnt[0] = 3;
    mcnt[1] = 2;
    for (int i = 1; i <= 8; i++) begin
      mstep(1'b0, 1'b1, 1'b1, 32'(i), 32'h0, 1'b0, 1'b1, acc);
      chk($sformatf("burst.acc%0d", i), acc, 1'b1);
    end
    mstep(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b1, acc);
    random_run(1'b0, 300);
    mstep(1'b0, 1'b1, 1'b0, 32'h1, 32'h11, 1'b0, 1'b0, acc);
    mstep(1'b0, 1'b1, 1'b1, 32'h22, 32'h2, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.valid0", ifa.oValid_BM0, 1'b0);
    chk("midrst.valid1", ifa.oValid_BM1, 1'b0);
`ifdef DISTRIBUTOR_COUNT_EN
    chk("midrst.count0", ca0, 16'h0);
    chk("midrst.count1", ca1, 16'h0);
`endif
    for (int i = 0; i < 4; i++) begin mq[i].delete(); mcnt[i] = 0; end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      mstep(1'b1, 1'b1, 1'(i), 32'(100 + i), 32'(i), 1'b1, 1'b1, acc);
      chk($sformatf("alt.acc%0d", i), acc, 1'b1);
    end
    for (int i = 0; i < 2; i++) mstep(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, acc);
    random_run(1'b1, 300);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
